// File: rtl/spram_ctrl_pkg.sv
// Shared types and helpers for the SPRAM word controller.
package spram_ctrl_pkg;
  localparam int SPRAM_AW = 14;
  localparam int BUS_AW   = 13;

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, RESP, STBY, WAKE
  } state_t;

  // Each byte strobe enables the two nibbles it covers.
  function automatic logic [3:0] strb_to_nibmask(input logic [1:0] strb);
    return {{2{strb[1]}}, {2{strb[0]}}};
  endfunction
endpackage

// File: rtl/spram_word_controller.sv
// 32-bit word port onto one 16K x 16 SPRAM; each word is two halfword cycles.
// Optional idle standby is enabled with `define SPRAM_STANDBY_EN.
module spram_word_controller
  import spram_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bus_valid,
  input  logic                bus_write,
  input  logic [BUS_AW-1:0]   bus_address,
  input  logic [3:0]          bus_wstrb,
  input  logic [31:0]         bus_wdata,
  output logic                bus_ready,
  output logic [31:0]         bus_rdata,
  output logic [SPRAM_AW-1:0] spram_address,
  output logic [15:0]         spram_datain,
  output logic [3:0]          spram_maskwren,
  output logic                spram_wren,
  output logic                spram_chipselect,
  output logic                spram_standby,
  output logic                spram_sleep,
  output logic                spram_poweroff,
  input  logic [15:0]         spram_dataout
);

  state_t              state, state_d;
  logic                ready_d;
  logic [31:0]         rdata_d;
  logic [SPRAM_AW-1:0] addr_d;
  logic [15:0]         datain_d;
  logic [3:0]          mask_d;
  logic                wren_d, cs_d;
  logic [15:0]         lo_q, lo_d;
  logic [BUS_AW-1:0]   req_addr, req_addr_d;
  logic [3:0]          req_wstrb, req_wstrb_d;
  logic [31:0]         req_wdata, req_wdata_d;

  // Source of the access being started: live bus in IDLE, latched request after wake.
  logic                start;
  logic                src_write;
  logic [BUS_AW-1:0]   src_addr;
  logic [3:0]          src_wstrb;
  logic [31:0]         src_wdata;

  assign spram_sleep    = 1'b0;
  assign spram_poweroff = 1'b1;

`ifdef SPRAM_STANDBY_EN
  localparam int ICW = $clog2(IDLE_CYCLES + 1);
  localparam int WCW = $clog2(WAKE_CYCLES + 1);

  logic           req_write, req_write_d;
  logic           standby_d;
  logic [ICW-1:0] idle_cnt, idle_cnt_d;
  logic [WCW-1:0] wake_cnt, wake_cnt_d;

  assign src_write = (state == IDLE) ? bus_write   : req_write;
  assign src_addr  = (state == IDLE) ? bus_address : req_addr;
  assign src_wstrb = (state == IDLE) ? bus_wstrb   : req_wstrb;
  assign src_wdata = (state == IDLE) ? bus_wdata   : req_wdata;
`else
  logic unused_cfg;
  assign unused_cfg    = ^{IDLE_CYCLES[0], WAKE_CYCLES[0], req_wstrb[1:0], req_wdata[15:0]};
  assign spram_standby = 1'b0;
  assign src_write     = bus_write;
  assign src_addr      = bus_address;
  assign src_wstrb     = bus_wstrb;
  assign src_wdata     = bus_wdata;
`endif

  always_comb begin
    state_d     = state;
    ready_d     = 1'b0;
    rdata_d     = bus_rdata;
    addr_d      = spram_address;
    datain_d    = spram_datain;
    mask_d      = spram_maskwren;
    wren_d      = spram_wren;
    cs_d        = spram_chipselect;
    lo_d        = lo_q;
    req_addr_d  = req_addr;
    req_wstrb_d = req_wstrb;
    req_wdata_d = req_wdata;
    start       = 1'b0;
`ifdef SPRAM_STANDBY_EN
    req_write_d = req_write;
    standby_d   = spram_standby;
    idle_cnt_d  = idle_cnt;
    wake_cnt_d  = wake_cnt;
`endif

    case (state)
      IDLE: begin
        if (bus_valid) begin
          start       = 1'b1;
          req_addr_d  = bus_address;
          req_wstrb_d = bus_wstrb;
          req_wdata_d = bus_wdata;
`ifdef SPRAM_STANDBY_EN
          req_write_d = bus_write;
          idle_cnt_d  = '0;
        end else if (idle_cnt == ICW'(IDLE_CYCLES - 1)) begin
          idle_cnt_d = ICW'(IDLE_CYCLES);
          standby_d  = 1'b1;
          state_d    = STBY;
        end else begin
          idle_cnt_d = idle_cnt + 1'b1;
`endif
        end
      end
      RD_LO: begin
        addr_d  = {req_addr, 1'b1};
        state_d = RD_HI;
      end
      RD_HI: begin
        lo_d    = spram_dataout;
        cs_d    = 1'b0;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        rdata_d = {spram_dataout, lo_q};
        ready_d = 1'b1;
        state_d = RESP;
      end
      WR_LO: begin
        if (req_wstrb[3:2] != 2'b00) begin
          addr_d   = {req_addr, 1'b1};
          datain_d = req_wdata[31:16];
          mask_d   = strb_to_nibmask(req_wstrb[3:2]);
          state_d  = WR_HI;
        end else begin
          cs_d    = 1'b0;
          wren_d  = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      WR_HI: begin
        cs_d    = 1'b0;
        wren_d  = 1'b0;
        ready_d = 1'b1;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
`ifdef SPRAM_STANDBY_EN
      STBY: begin
        if (bus_valid) begin
          req_addr_d  = bus_address;
          req_wstrb_d = bus_wstrb;
          req_wdata_d = bus_wdata;
          req_write_d = bus_write;
          idle_cnt_d  = '0;
          standby_d   = 1'b0;
          wake_cnt_d  = WCW'(WAKE_CYCLES - 1);
          state_d     = WAKE;
        end
      end
      WAKE: begin
        if (wake_cnt == '0) start = 1'b1;
        else                wake_cnt_d = wake_cnt - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Writes skip any half whose strobe pair is empty; an all-zero strobe never touches the SPRAM.
    if (start) begin
      if (!src_write) begin
        addr_d  = {src_addr, 1'b0};
        cs_d    = 1'b1;
        wren_d  = 1'b0;
        state_d = RD_LO;
      end else if (src_wstrb[1:0] != 2'b00) begin
        addr_d   = {src_addr, 1'b0};
        datain_d = src_wdata[15:0];
        mask_d   = strb_to_nibmask(src_wstrb[1:0]);
        cs_d     = 1'b1;
        wren_d   = 1'b1;
        state_d  = WR_LO;
      end else if (src_wstrb[3:2] != 2'b00) begin
        addr_d   = {src_addr, 1'b1};
        datain_d = src_wdata[31:16];
        mask_d   = strb_to_nibmask(src_wstrb[3:2]);
        cs_d     = 1'b1;
        wren_d   = 1'b1;
        state_d  = WR_HI;
      end else begin
        ready_d = 1'b1;
        state_d = RESP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bus_ready        <= 1'b0;
      bus_rdata        <= '0;
      spram_address    <= '0;
      spram_datain     <= '0;
      spram_maskwren   <= '0;
      spram_wren       <= 1'b0;
      spram_chipselect <= 1'b0;
      lo_q             <= '0;
      req_addr         <= '0;
      req_wstrb        <= '0;
      req_wdata        <= '0;
    end else begin
      state            <= state_d;
      bus_ready        <= ready_d;
      bus_rdata        <= rdata_d;
      spram_address    <= addr_d;
      spram_datain     <= datain_d;
      spram_maskwren   <= mask_d;
      spram_wren       <= wren_d;
      spram_chipselect <= cs_d;
      lo_q             <= lo_d;
      req_addr         <= req_addr_d;
      req_wstrb        <= req_wstrb_d;
      req_wdata        <= req_wdata_d;
    end
  end

`ifdef SPRAM_STANDBY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spram_standby <= 1'b0;
      req_write     <= 1'b0;
      idle_cnt      <= '0;
      wake_cnt      <= '0;
    end else begin
      spram_standby <= standby_d;
      req_write     <= req_write_d;
      idle_cnt      <= idle_cnt_d;
      wake_cnt      <= wake_cnt_d;
    end
  end
`endif

endmodule

// File: doc/spram_word_controller.md
Name: spram_word_controller

Overview:
- Bus-side initiator for a single SB_SPRAM256KA (16K x 16-bit).
- Presents a 32-bit word-addressed CPU memory port (valid/ready, byte strobes).
- Each word access is split into two sequential halfword SPRAM accesses (low half first), with byte strobes converted to nibble write masks.
- Sits between the CPU bus arbiter and the SPRAM primitive; it is the only driver of the SPRAM pins.

Parameters:
- IDLE_CYCLES, 16: idle cycles before entering standby (used only with SPRAM_STANDBY_EN).
- WAKE_CYCLES, 2: cycles held after standby deassertion before the first access (used only with SPRAM_STANDBY_EN; minimum 1).

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- bus_valid  input  1  request valid; held by master until bus_ready.
- bus_write  input  1  1 = write, 0 = read.
- bus_address  input  13  word address (8K words).
- bus_wstrb  input  4  byte write strobes; bit n covers wdata[8n+7:8n].
- bus_wdata  input  32  write data.
- bus_ready  output  1  one-cycle completion pulse (registered).
- bus_rdata  output  32  read data (registered); valid while bus_ready=1.
- spram_address  output  14  SPRAM halfword address (registered).
- spram_datain  output  16  SPRAM write data (registered).
- spram_maskwren  output  4  SPRAM nibble write mask (registered).
- spram_wren  output  1  SPRAM write enable (registered).
- spram_chipselect  output  1  SPRAM chip select (registered).
- spram_standby  output  1  SPRAM standby (registered).
- spram_sleep  output  1  constant 0.
- spram_poweroff  output  1  constant 1 (SPRAM pin is active-low).
- spram_dataout  input  16  SPRAM read data; valid the cycle after the sampling edge.

Behaviour:
- Reset (async): state=IDLE, bus_ready=0, bus_rdata=0, spram_address=0, spram_datain=0, spram_maskwren=0, spram_wren=0, spram_chipselect=0, spram_standby=0. Idle counter=0.
- Strobe to mask mapping: mask[1:0]={2{strb[0]}}, mask[3:2]={2{strb[1]}}.
  - Low half uses wstrb[1:0].
  - High half uses wstrb[3:2].
- Halfword address mapping: low half = {bus_address,1'b0}, high half = {bus_address,1'b1}.
- State IDLE:
  - Request is sampled only here; bus_valid=1 latches the request.
  - Read: drive low-half read (cs=1, wren=0); go to RD_LO.
  - Write: write to the first half with a nonzero strobe pair; skip a half whose pair is 00.
  - Write with wstrb=0000: no SPRAM cycle; go directly to RESP.
- State RD_LO: SPRAM samples the low address at this edge. Drive high-half address; go to RD_HI.
- State RD_HI: capture spram_dataout into lo_q (low half); deassert cs; go to RD_CAP.
- State RD_CAP: bus_rdata <= {spram_dataout, lo_q}; go to RESP.
- Write states WR_LO, WR_HI:
  - Each state presents one half for exactly one sampling edge.
  - cs and wren are deasserted on exit from the last half written.
- State RESP: bus_ready=1 for exactly one cycle; go to IDLE. bus_valid is ignored during RESP.
- Latency from the accepting edge to the bus_ready cycle:
  - Read: 4 cycles.
  - Write, both halves: 3 cycles.
  - Write, one half: 2 cycles.
  - Write, wstrb=0: 1 cycle.
  - Back-to-back requests: the next request is accepted on the edge after the RESP cycle.
- bus_rdata holds its value until the next read completes. Writes do not modify bus_rdata.
- Outside an access: spram_chipselect=0 and spram_wren=0.
- Reset mid-write may leave the word half-written; no recovery is required.
- Reset mid-read drops the response; no bus_ready is issued.

Optional Feature:
- Macro: SPRAM_STANDBY_EN.
- With the macro:
  - Idle counter increments each IDLE cycle with bus_valid=0 and saturates at IDLE_CYCLES.
  - At IDLE_CYCLES, spram_standby<=1 (state STBY).
  - In STBY, bus_valid=1 sets spram_standby<=0 and enters WAKE for WAKE_CYCLES cycles. The access then starts as if freshly accepted in IDLE, with the request latched at the STBY edge.
  - The counter clears on any accepted request.
- Without the macro: spram_standby is tied 0, the counter and STBY/WAKE states are absent, and IDLE_CYCLES/WAKE_CYCLES are unused.

Decomposition:
- Shared package spram_ctrl_pkg:
  - state enum (IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, RESP, STBY, WAKE);
  - constants SPRAM_AW=14, BUS_AW=13;
  - function strb_to_nibmask (2-bit strobe to 4-bit mask).
- No sub-module is needed; the FSM is a single module.
- The bench instantiates the SB_SPRAM256KA model as the responder.

Test Plan:
- Write addr 0x0005 data 0xDEADBEEF wstrb 1111, then read 0x0005:
  - rdata=0xDEADBEEF;
  - bus_ready 4 cycles after read acceptance;
  - SPRAM addresses 0x000A then 0x000B.
- Preload 0x0005=0xDEADBEEF; write wdata 0x11223344 wstrb 0100; read:
  - result 0xDE22BEEF;
  - only one SPRAM write (addr 0x000B, mask 0011);
  - ready 2 cycles after acceptance.
- Write with wstrb 0000:
  - ready 1 cycle after acceptance;
  - spram_chipselect never asserted;
  - memory unchanged.
- Back-to-back reads 0x1FFF then 0x0000, bus_valid held high:
  - second request accepted the edge after RESP;
  - addresses 0x3FFE/0x3FFF then 0x0000/0x0001;
  - no overlap of cs cycles.
- Assert reset during RD_HI:
  - all outputs 0 immediately (async);
  - no bus_ready pulse;
  - a subsequent read returns correct data.
- With SPRAM_STANDBY_EN and defaults:
  - 16 idle cycles -> spram_standby=1;
  - a request then deasserts standby;
  - first cs asserted 2 cycles later;
  - read data correct.
